// File: rtl/stream_arb_pkg.sv
// Shared helpers and types for stream_rr_arbiter (optional packet lock: STREAM_ARB_PKT_LOCK_EN).
// src_w() sizes requester indices; stream_beat_t is the output beat at the default configuration.
package stream_arb_pkg;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEAT_DATA_W = 64;
    localparam int BEAT_SRC_W  = src_w(4);

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic [BEAT_SRC_W-1:0]  src;
        logic                   last;
    } stream_beat_t;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit scanning upward from last+1,
// wrapping modulo N. Returns one-hot grant, its index, and whether anything was picked.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = src_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = SW'(j);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams into one registered output stage with source tag.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant on one requester until it sends in_last.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int DATA_W  = 64,
    parameter  int NUM_REQ = 4,
    localparam int SRC_W   = src_w(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          in_vld,
    input  logic [NUM_REQ*DATA_W-1:0]   in_data,
    input  logic [NUM_REQ-1:0]          in_last,
    output logic [NUM_REQ-1:0]          in_rdy,
    output logic                        out_vld,
    output logic [DATA_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    output logic                        out_last,
    input  logic                        out_rdy
);

    if (NUM_REQ < 1) begin : g_bad_num_req
        $error("stream_rr_arbiter: NUM_REQ must be >= 1");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
        logic              last;
    } beat_t;

    beat_t              beat_q, beat_d;
    logic               out_vld_q, out_vld_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0] gnt;
    logic [SRC_W-1:0]   gidx;
    logic               gnt_vld;
    logic               open;
    logic               accept;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req  (in_vld),
        .last (last_grant_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef STREAM_ARB_PKT_LOCK_EN
    logic               lock_q, lock_d;
    logic [SRC_W-1:0]   owner_q, owner_d;

    // While locked the owner keeps the slot even across gaps in its valid.
    always_comb begin
        gnt     = lock_q ? (NUM_REQ'(1) << owner_q) : pick_gnt;
        gidx    = lock_q ? owner_q : pick_idx;
        gnt_vld = lock_q || pick_any;
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        if (accept) begin
            lock_d  = !in_last[gidx];
            owner_d = gidx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end
`else
    always_comb begin
        gnt     = pick_gnt;
        gidx    = pick_idx;
        gnt_vld = pick_any;
    end
`endif

    always_comb begin
        open   = !out_vld_q || out_rdy;
        in_rdy = (open && gnt_vld) ? (gnt & in_vld) : '0;
        accept = |(in_vld & in_rdy);
    end

    always_comb begin
        beat_d       = beat_q;
        out_vld_d    = out_vld_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            beat_d.data  = in_data[int'(gidx)*DATA_W +: DATA_W];
            beat_d.src   = gidx;
            beat_d.last  = in_last[gidx];
            out_vld_d    = 1'b1;
            last_grant_d = gidx;
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q       <= '0;
            out_vld_q    <= 1'b0;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
        end else begin
            beat_q       <= beat_d;
            out_vld_q    <= out_vld_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = beat_q.data;
    assign out_src  = beat_q.src;
    assign out_last = beat_q.last;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (NUM_REQ=4, DATA_W=64); lock scenarios run only when
// STREAM_ARB_PKT_LOCK_EN is defined.
module tb_stream_rr_arbiter;
    import stream_arb_pkg::*;

    localparam int DATA_W  = 64;
    localparam int NUM_REQ = 4;
    localparam int SRC_W   = src_w(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        in_vld;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_last;
    logic [NUM_REQ-1:0]        in_rdy;
    logic                      out_vld;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_last;
    logic                      out_rdy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_src  (out_src),
        .out_last (out_last),
        .out_rdy  (out_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DATA_W-1:0] v);
        in_data[i*DATA_W +: DATA_W] = v;
    endtask

    int fair_exp [5] = '{0, 1, 2, 3, 0};
    int skip_exp [4] = '{3, 0, 3, 0};

    initial begin
        rst     = 1'b1;
        in_vld  = '0;
        in_data = '0;
        in_last = '1;
        out_rdy = 1'b1;

        // Reset, single requester on lane 2.
        in_vld = 4'b0100;
        set_lane(2, 64'hA5);
        tick();
        tick();
        chk("rst_out_vld",  64'(out_vld),  64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src",  64'(out_src),  64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        rst = 1'b0;
        #1;
        chk("single_in_rdy", 64'(in_rdy), 64'h4);
        tick();
        chk("single_out_vld",  64'(out_vld),  64'd1);
        chk("single_out_data", 64'(out_data), 64'hA5);
        chk("single_out_src",  64'(out_src),  64'd2);
        chk("single_out_last", 64'(out_last), 64'd1);
        in_vld = '0;
        tick();
        chk("drain_out_vld", 64'(out_vld), 64'd0);

        // Fairness from a fresh reset: 0,1,2,3,0 at one beat per cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 64'h100 + 64'(i));
        in_vld = 4'b1111;
        #1;
        chk("fair_first_rdy", 64'(in_rdy), 64'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fair_out_vld",  64'(out_vld),  64'd1);
            chk("fair_out_src",  64'(out_src),  64'(fair_exp[i]));
            chk("fair_out_data", 64'(out_data), 64'h100 + 64'(fair_exp[i]));
        end

        // Backpressure with beat from requester 0 held.
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_rdy",   64'(in_rdy),   64'd0);
            chk("stall_out_vld",  64'(out_vld),  64'd1);
            chk("stall_out_src",  64'(out_src),  64'd0);
            chk("stall_out_data", 64'(out_data), 64'h100);
            tick();
        end
        out_rdy = 1'b1;
        #1;
        chk("release_in_rdy", 64'(in_rdy), 64'h2);
        tick();
        chk("release_out_src", 64'(out_src), 64'd1);

        // Skip idle requesters: only 0 and 3 valid, last grant was 1.
        in_vld = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("skip_out_src",  64'(out_src),  64'(skip_exp[i]));
            chk("skip_out_data", 64'(out_data), 64'h100 + 64'(skip_exp[i]));
        end
        in_vld = '0;
        tick();
        chk("skip_drain_vld", 64'(out_vld), 64'd0);

`ifdef STREAM_ARB_PKT_LOCK_EN
        // Packet lock: requester 1 sends three beats, last on the third, with 0 and 2 also valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_vld  = 4'b0110;
        in_last = 4'b1101;
        set_lane(1, 64'h11);
        tick();
        chk("lock_b0_src",  64'(out_src),  64'd1);
        chk("lock_b0_last", 64'(out_last), 64'd0);
        in_vld = 4'b0111;
        set_lane(1, 64'h12);
        #1;
        chk("lock_b1_rdy", 64'(in_rdy), 64'h2);
        tick();
        chk("lock_b1_src",  64'(out_src),  64'd1);
        chk("lock_b1_data", 64'(out_data), 64'h12);
        in_vld = 4'b0101;
        #1;
        chk("lock_gap_rdy", 64'(in_rdy), 64'h0);
        tick();
        chk("lock_gap_vld", 64'(out_vld), 64'd0);
        in_vld  = 4'b0111;
        in_last = 4'b1111;
        set_lane(1, 64'h13);
        tick();
        chk("lock_b2_src",  64'(out_src),  64'd1);
        chk("lock_b2_last", 64'(out_last), 64'd1);
        tick();
        chk("lock_after_src", 64'(out_src), 64'd2);

        // Mid-packet reset: requester 0 opens a packet, then reset.
        in_vld  = 4'b0001;
        in_last = 4'b1110;
        tick();
        chk("mid_open_src", 64'(out_src), 64'd0);
        rst     = 1'b1;
        in_vld  = 4'b0110;
        in_last = 4'b1111;
        tick();
        chk("mid_rst_vld", 64'(out_vld), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_first_rdy", 64'(in_rdy), 64'h2);
        tick();
        chk("mid_first_src", 64'(out_src), 64'd1);
        in_vld = '0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
